// File: rtl/axi_burst_pkg.sv
// Shared constants, state encoding and the 4 KB boundary helper
// used by the AXI4 INCR burst master.
package axi_burst_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      W_ADDR,
      W_DATA,
      W_RESP,
      R_ADDR,
      R_DATA,
      DONE
   } state_t;

   // True when a burst starting at this page offset runs past the end of its 4 KB page.
   function automatic logic crosses_4k(input logic [11:0] addr,
                                       input logic [7:0]  len,
                                       input logic [8:0]  bytes_per_beat);
      logic [17:0] end_addr;
      end_addr = 18'(addr) + (18'(len) + 18'd1) * 18'(bytes_per_beat);
      return end_addr > 18'd4096;
   endfunction

endpackage

// File: rtl/axi_burst_master.sv
// AXI4 master running one INCR read or write burst per command, with
// length/4 KB rejection, streaming data ports and a completion status.
module axi_burst_master
   import axi_burst_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter int MAX_BURST  = 16
) (
   input  logic                    clk,
   input  logic                    resetn,
   output logic [ID_WIDTH-1:0]     awid,
   output logic [ADDR_WIDTH-1:0]   awaddr,
   output logic [7:0]              awlen,
   output logic [2:0]              awsize,
   output logic [1:0]              awburst,
   output logic                    awvalid,
   input  logic                    awready,
   output logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH/8-1:0] wstrb,
   output logic                    wlast,
   output logic                    wvalid,
   input  logic                    wready,
   input  logic [ID_WIDTH-1:0]     bid,
   input  logic [1:0]              bresp,
   input  logic                    bvalid,
   output logic                    bready,
   output logic [ID_WIDTH-1:0]     arid,
   output logic [ADDR_WIDTH-1:0]   araddr,
   output logic [7:0]              arlen,
   output logic [2:0]              arsize,
   output logic [1:0]              arburst,
   output logic                    arvalid,
   input  logic                    arready,
   input  logic [ID_WIDTH-1:0]     rid,
   input  logic [DATA_WIDTH-1:0]   rdata,
   input  logic [1:0]              rresp,
   input  logic                    rlast,
   input  logic                    rvalid,
   output logic                    rready,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ID_WIDTH-1:0]     cmd_id,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [7:0]              cmd_len,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic [DATA_WIDTH/8-1:0] wr_strb,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   output logic [DATA_WIDTH-1:0]   rd_data,
   output logic                    rd_last,
   output logic                    rd_valid,
   input  logic                    rd_ready,
   output logic                    done_valid,
   output logic [1:0]              done_resp,
   output logic                    busy
);

   localparam int                    BYTES     = DATA_WIDTH / 8;
   localparam logic [2:0]            SIZE      = 3'($clog2(BYTES));
   localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(BYTES - 1);
   localparam logic [7:0]            MAX_LEN   = 8'(MAX_BURST - 1);

   state_t                  state;
   state_t                  state_next;
   logic [ID_WIDTH-1:0]     id_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [7:0]              len_q;
   logic [7:0]              count;
   logic [1:0]              resp_q;
   logic                    err_q;
   logic [ADDR_WIDTH-1:0]   cmd_addr_aligned;
   logic                    reject;
   logic                    w_beat;
   logic                    r_beat;
   logic                    last_count;
   logic [1:0]              r_worst;
   logic                    r_err;

   assign cmd_addr_aligned = cmd_addr & ADDR_MASK;
   assign reject     = (cmd_len > MAX_LEN) ||
                       crosses_4k(cmd_addr_aligned[11:0], cmd_len, 9'(BYTES));
   assign w_beat     = wvalid && wready;
   assign r_beat     = rvalid && rready;
   assign last_count = (count == len_q);
   assign r_worst    = (rresp > resp_q) ? rresp : resp_q;
   // A beat is malformed when rlast and the expected final count disagree.
   assign r_err      = err_q || (rid != id_q) || (rlast != last_count);

   assign awid      = id_q;
   assign awaddr    = addr_q;
   assign awlen     = len_q;
   assign awsize    = SIZE;
   assign awburst   = BURST_INCR;
   assign arid      = id_q;
   assign araddr    = addr_q;
   assign arlen     = len_q;
   assign arsize    = SIZE;
   assign arburst   = BURST_INCR;
   assign wdata     = wr_data;
   assign wstrb     = wr_strb;
   assign rd_data   = rdata;
   assign rd_last   = rlast;
   assign done_resp = resp_q;
   assign busy      = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!resetn) state <= IDLE;
      else         state <= state_next;
   end

   // Command latch, beat counter and running response.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         id_q   <= '0;
         addr_q <= '0;
         len_q  <= '0;
         count  <= '0;
         resp_q <= RESP_OKAY;
         err_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (cmd_valid) begin
               id_q   <= cmd_id;
               addr_q <= cmd_addr_aligned;
               len_q  <= cmd_len;
               count  <= '0;
               err_q  <= 1'b0;
               resp_q <= reject ? RESP_DECERR : RESP_OKAY;
            end
            W_DATA: if (w_beat) count <= last_count ? 8'd0 : count + 8'd1;
            W_RESP: if (bvalid) resp_q <= (bid != id_q) ? RESP_SLVERR : bresp;
            R_DATA: if (r_beat) begin
               if (rlast) begin
                  count  <= '0;
                  resp_q <= r_err ? RESP_SLVERR : r_worst;
               end else begin
                  resp_q <= r_worst;
                  err_q  <= r_err;
                  if (count != 8'hFF) count <= count + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_next = state;
      cmd_ready  = 1'b0;
      awvalid    = 1'b0;
      wvalid     = 1'b0;
      wlast      = 1'b0;
      wr_ready   = 1'b0;
      bready     = 1'b0;
      arvalid    = 1'b0;
      rready     = 1'b0;
      rd_valid   = 1'b0;
      done_valid = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) state_next = reject ? DONE : (cmd_write ? W_ADDR : R_ADDR);
         end
         W_ADDR: begin
            awvalid = 1'b1;
            if (awready) state_next = W_DATA;
         end
         W_DATA: begin
            wvalid   = wr_valid;
            wr_ready = wready;
            wlast    = last_count;
            if (wr_valid && wready && last_count) state_next = W_RESP;
         end
         W_RESP: begin
            bready = 1'b1;
            if (bvalid) state_next = DONE;
         end
         R_ADDR: begin
            arvalid = 1'b1;
            if (arready) state_next = R_DATA;
         end
         R_DATA: begin
            rd_valid = rvalid;
            rready   = rd_ready;
            if (rvalid && rd_ready && rlast) state_next = DONE;
         end
         DONE: begin
            done_valid = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_axi_burst_master.sv
// Scoreboard bench for axi_burst_master: directed commands against a
// behavioural AXI slave, with a monitor popping expected beats/responses.
module tb_axi_burst_master;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [3:0]  awid, arid, bid, rid;
   logic [31:0] awaddr, araddr, wdata, rdata, rd_data, wr_data;
   logic [7:0]  awlen, arlen, cmd_len;
   logic [2:0]  awsize, arsize;
   logic [1:0]  awburst, arburst, bresp, rresp, done_resp;
   logic [3:0]  wstrb, wr_strb, cmd_id;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rlast, rvalid, rready;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr;
   logic        wr_valid, wr_ready, rd_last, rd_valid, rd_ready;
   logic        done_valid, busy;

   logic [31:0] mem [0:1023];
   logic [63:0] exp_aw[$], exp_ar[$], exp_w[$], exp_rd[$], exp_done[$];
   int          tests_run = 0;
   int          tests_failed = 0;
   bit          stall_r = 1'b0;
   bit          rd_toggle = 1'b0;
   logic [3:0]  bid_flip = 4'h0;
   int          early_last = -1;

   always #5 clk = ~clk;

   axi_burst_master #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .MAX_BURST(16)
   ) dut (
      .clk(clk), .resetn(resetn),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_id(cmd_id),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .done_valid(done_valid), .done_resp(done_resp), .busy(busy)
   );

   function automatic logic [63:0] aExp(input logic [31:0] addr, input logic [7:0] len);
      return {19'd0, addr, len, 3'd2, 2'b01};
   endfunction

   function automatic logic [63:0] wExp(input logic [31:0] data, input logic last);
      return {27'd0, data, 4'hF, last};
   endfunction

   function automatic logic [63:0] rdExp(input logic [31:0] data, input logic last);
      return {31'd0, data, last};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic reportMissing(input string name);
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s: event seen with no expectation queued (got 1, expected 0)", name);
   endtask

   task automatic reportTimeout(input string name);
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s: timed out (got 0, expected 1)", name);
   endtask

   task automatic applyStimulus(input logic write, input logic [3:0] id,
                                input logic [31:0] addr, input logic [7:0] len);
      bit ok = 1'b0;
      cmd_valid = 1'b1;
      cmd_write = write;
      cmd_id    = id;
      cmd_addr  = addr;
      cmd_len   = len;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (cmd_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) reportTimeout("cmd_accept");
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic feedWrite(input logic [31:0] first, input int len, input int abort_at);
      for (int b = 0; b <= len; b++) begin
         bit ok = 1'b0;
         wr_valid = 1'b1;
         wr_data  = first + 32'(b);
         wr_strb  = 4'hF;
         if (b == abort_at) begin
            resetn = 1'b0;
            tick();
            wr_valid = 1'b0;
            return;
         end
         for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (wr_ready) begin
               ok = 1'b1;
               break;
            end
            tick();
         end
         if (!ok) begin
            reportTimeout("wr_handshake");
            break;
         end
         tick();
      end
      wr_valid = 1'b0;
   endtask

   task automatic waitDone();
      bit ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (done_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) reportTimeout("done_wait");
      tick();
   endtask

   // Behavioural zero-wait slave with knobs for rvalid stalls, early rlast and bid corruption.
   initial begin : slave
      logic [31:0] aw_base, ar_base;
      logic [3:0]  aw_id_s, ar_id_s;
      int          w_beat, r_beat, ar_len;
      bit          r_active, in_reset, hs_aw, hs_w, hs_b, hs_ar, hs_r, last_w, last_r;
      logic [31:0] aw_cap, ar_cap, wd_cap;
      logic [3:0]  awid_cap, arid_cap;
      logic [7:0]  arlen_cap;
      for (int i = 0; i < 1024; i++) mem[i] = 32'hC000_0000 | 32'(i);
      awready = 1'b1; wready = 1'b1; arready = 1'b1;
      bvalid = 1'b0; bid = '0; bresp = 2'b00;
      rvalid = 1'b0; rid = '0; rdata = '0; rresp = 2'b00; rlast = 1'b0;
      aw_base = '0; ar_base = '0; aw_id_s = '0; ar_id_s = '0;
      w_beat = 0; r_beat = 0; ar_len = 0; r_active = 1'b0;
      forever begin
         @(negedge clk);
         in_reset  = !resetn;
         hs_aw     = awvalid && awready;
         hs_w      = wvalid && wready;
         hs_b      = bvalid && bready;
         hs_ar     = arvalid && arready;
         hs_r      = rvalid && rready;
         last_w    = wlast;
         last_r    = rlast;
         aw_cap    = awaddr;
         awid_cap  = awid;
         wd_cap    = wdata;
         ar_cap    = araddr;
         arid_cap  = arid;
         arlen_cap = arlen;
         tick();
         if (in_reset) begin
            bvalid = 1'b0; rvalid = 1'b0; r_active = 1'b0; w_beat = 0; r_beat = 0;
            continue;
         end
         if (hs_aw) begin
            aw_base = aw_cap;
            aw_id_s = awid_cap;
            w_beat  = 0;
         end
         if (hs_b) bvalid = 1'b0;
         if (hs_w) begin
            mem[int'(aw_base >> 2) + w_beat] = wd_cap;
            w_beat++;
            if (last_w) begin
               bvalid = 1'b1;
               bid    = aw_id_s ^ bid_flip;
               bresp  = 2'b00;
            end
         end
         if (hs_ar) begin
            ar_base  = ar_cap;
            ar_id_s  = arid_cap;
            ar_len   = int'(arlen_cap);
            r_beat   = 0;
            r_active = 1'b1;
         end
         if (hs_r) begin
            r_beat++;
            rvalid = 1'b0;
            if (last_r) r_active = 1'b0;
         end
         if (r_active && !rvalid && (!stall_r || $urandom_range(0, 1) == 1)) rvalid = 1'b1;
         rdata = mem[(int'(ar_base >> 2) + r_beat) % 1024];
         rlast = (r_beat == ar_len) || (r_beat == early_last);
         rid   = ar_id_s;
      end
   end

   initial begin : rd_drive
      rd_ready = 1'b1;
      forever begin
         tick();
         rd_ready = rd_toggle ? !rd_ready : 1'b1;
      end
   end

   // Monitor: pops the scoreboard whenever the DUT completes a handshake or a command.
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (resetn) begin
            if (awvalid && awready) begin
               if (exp_aw.size() == 0) reportMissing("aw_unexpected");
               else checkOutput("aw_fields", {19'd0, awaddr, awlen, awsize, awburst}, exp_aw.pop_front());
            end
            if (arvalid && arready) begin
               if (exp_ar.size() == 0) reportMissing("ar_unexpected");
               else checkOutput("ar_fields", {19'd0, araddr, arlen, arsize, arburst}, exp_ar.pop_front());
            end
            if (wvalid && wready) begin
               if (exp_w.size() == 0) reportMissing("w_unexpected");
               else checkOutput("w_beat", {27'd0, wdata, wstrb, wlast}, exp_w.pop_front());
            end
            if (rd_valid && rd_ready) begin
               if (exp_rd.size() == 0) reportMissing("rd_unexpected");
               else checkOutput("rd_beat", {31'd0, rd_data, rd_last}, exp_rd.pop_front());
            end
            if (done_valid) begin
               if (exp_done.size() == 0) reportMissing("done_unexpected");
               else checkOutput("done_resp", {62'd0, done_resp}, exp_done.pop_front());
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish (got timeout, expected $finish)");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_id = '0; cmd_addr = '0; cmd_len = '0;
      wr_valid = 1'b0; wr_data = '0; wr_strb = '0;
      resetn = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      checkOutput("rst_cmd_ready",  cmd_ready,  1);
      checkOutput("rst_busy",       busy,       0);
      checkOutput("rst_awvalid",    awvalid,    0);
      checkOutput("rst_arvalid",    arvalid,    0);
      checkOutput("rst_done_valid", done_valid, 0);
      checkOutput("rst_done_resp",  done_resp,  0);
      checkOutput("rst_wr_ready",   wr_ready,   0);
      checkOutput("rst_bready",     bready,     0);
      tick();
      resetn = 1'b1;
      tick();

      // Four-beat write to 0x100
      exp_aw.push_back(aExp(32'h100, 8'd3));
      for (int b = 0; b < 4; b++) exp_w.push_back(wExp(32'hA0 + 32'(b), b == 3));
      exp_done.push_back(64'd0);
      applyStimulus(1'b1, 4'h1, 32'h100, 8'd3);
      checkOutput("aw_valid_latency", awvalid, 1);
      checkOutput("busy_active", busy, 1);
      feedWrite(32'hA0, 3, -1);
      waitDone();
      for (int i = 0; i < 4; i++) checkOutput("mem_write", mem[64 + i], 32'hA0 + 32'(i));

      // Read the same burst back with rvalid stalls and a toggling rd_ready
      stall_r = 1'b1;
      rd_toggle = 1'b1;
      exp_ar.push_back(aExp(32'h100, 8'd3));
      for (int b = 0; b < 4; b++) exp_rd.push_back(rdExp(32'hA0 + 32'(b), b == 3));
      exp_done.push_back(64'd0);
      applyStimulus(1'b0, 4'h2, 32'h100, 8'd3);
      waitDone();
      stall_r = 1'b0;
      rd_toggle = 1'b0;

      // Write crossing the 4 KB page: rejected with DECERR, no AXI traffic
      exp_done.push_back(64'd3);
      applyStimulus(1'b1, 4'h3, 32'hFF8, 8'd3);
      checkOutput("reject_no_awvalid", awvalid, 0);
      @(negedge clk);
      checkOutput("reject_done_latency", done_valid, 1);
      checkOutput("reject_not_ready", cmd_ready, 0);
      tick();
      @(negedge clk);
      checkOutput("reject_ready_latency", cmd_ready, 1);
      tick();

      // Length 17 rejected, length 16 accepted
      exp_done.push_back(64'd3);
      applyStimulus(1'b0, 4'h4, 32'h200, 8'd16);
      waitDone();
      exp_ar.push_back(aExp(32'h200, 8'd15));
      for (int b = 0; b < 16; b++) exp_rd.push_back(rdExp(32'hC000_0080 + 32'(b), b == 15));
      exp_done.push_back(64'd0);
      applyStimulus(1'b0, 4'h4, 32'h200, 8'd15);
      waitDone();

      // Early rlast on beat 2 of a 4-beat read
      early_last = 1;
      exp_ar.push_back(aExp(32'h300, 8'd3));
      exp_rd.push_back(rdExp(32'hC000_00C0, 1'b0));
      exp_rd.push_back(rdExp(32'hC000_00C1, 1'b1));
      exp_done.push_back(64'd2);
      applyStimulus(1'b0, 4'h5, 32'h300, 8'd3);
      waitDone();
      early_last = -1;

      // Single-beat write whose bid comes back wrong
      bid_flip = 4'h8;
      exp_aw.push_back(aExp(32'h400, 8'd0));
      exp_w.push_back(wExp(32'h55, 1'b1));
      exp_done.push_back(64'd2);
      applyStimulus(1'b1, 4'h6, 32'h400, 8'd0);
      feedWrite(32'h55, 0, -1);
      waitDone();
      bid_flip = 4'h0;
      checkOutput("idle_after_error", busy, 0);

      // Reset during beat 2 of a write
      exp_aw.push_back(aExp(32'h500, 8'd3));
      exp_w.push_back(wExp(32'hB0, 1'b0));
      exp_w.push_back(wExp(32'hB1, 1'b0));
      applyStimulus(1'b1, 4'h7, 32'h500, 8'd3);
      feedWrite(32'hB0, 3, 2);
      @(negedge clk);
      checkOutput("abort_awvalid",    awvalid,    0);
      checkOutput("abort_wvalid",     wvalid,     0);
      checkOutput("abort_arvalid",    arvalid,    0);
      checkOutput("abort_done_valid", done_valid, 0);
      checkOutput("abort_cmd_ready",  cmd_ready,  1);
      checkOutput("abort_busy",       busy,       0);
      tick();
      resetn = 1'b1;
      tick();
      checkOutput("abort_w_drained", exp_w.size(), 0);
      exp_aw.push_back(aExp(32'h600, 8'd0));
      exp_w.push_back(wExp(32'h77, 1'b1));
      exp_done.push_back(64'd0);
      applyStimulus(1'b1, 4'h8, 32'h600, 8'd0);
      feedWrite(32'h77, 0, -1);
      waitDone();
      checkOutput("mem_after_reset", mem[384], 32'h77);

      repeat (5) tick();
      checkOutput("left_aw",   exp_aw.size(),   0);
      checkOutput("left_ar",   exp_ar.size(),   0);
      checkOutput("left_w",    exp_w.size(),    0);
      checkOutput("left_rd",   exp_rd.size(),   0);
      checkOutput("left_done", exp_done.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/axi_burst_master.md
# axi_burst_master

Parametrised AXI4 master that executes one INCR burst read or write per command, replacing single-beat-only master logic. Sits between a local command/stream client (DMA or pixel engine) and the AXI interconnect. Adds multi-beat bursts, 4 KB boundary and length checking, streaming write/read data ports, response ID checking, and a per-command completion status.

## Interface
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, AXI data width; power of two, 8..256
- ID_WIDTH, 4, AXI ID width
- MAX_BURST, 16, maximum beats per burst; 1..256
- Clocking and reset: clock clk; reset resetn, synchronous, active-low.
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- aw*/w*/b*/ar*/r*  AXI4 master ports  standard widths  awid, awaddr, awlen[7:0], awsize[2:0], awburst[1:0], awvalid, awready; wdata, wstrb, wlast, wvalid, wready; bid, bresp, bvalid, bready; ar* mirrors aw*; rid, rdata, rresp, rlast, rvalid, rready
- cmd_valid / cmd_ready  in / out  1  command handshake
- cmd_write  in  1  1 = write, 0 = read
- cmd_id  in  ID_WIDTH  transaction ID
- cmd_addr  in  ADDR_WIDTH  byte address; low log2(DATA_WIDTH/8) bits ignored (forced 0)
- cmd_len  in  8  beats minus 1
- wr_data / wr_strb / wr_valid / wr_ready  in/in/in/out  DATA_WIDTH / DATA_WIDTH/8 / 1 / 1  write data stream
- rd_data / rd_last / rd_valid / rd_ready  out/out/out/in  DATA_WIDTH / 1 / 1 / 1  read data stream
- done_valid  out  1  one-cycle completion pulse
- done_resp  out  2  final response: OKAY 00, SLVERR 10, DECERR 11
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, W_ADDR, W_DATA, W_RESP, R_ADDR, R_DATA, DONE.
- IDLE: cmd_ready=1. On cmd_valid, latch the command and perform the reject check:
  - Reject if cmd_len > MAX_BURST-1, or if the burst crosses a 4 KB boundary (aligned addr[11:0] + (cmd_len+1)*DATA_WIDTH/8 > 4096).
  - Rejected command → DONE with done_resp=11. No AXI traffic is issued.
  - Accepted command → W_ADDR or R_ADDR.
- W_ADDR / R_ADDR: assert a*valid with a*len=cmd_len, a*size=log2(DATA_WIDTH/8), a*burst=01 (INCR). Hold all fields until a*ready.
- W_DATA: wvalid=wr_valid, wr_ready=wready, wdata/wstrb pass through combinationally. Beat counter increments on each handshake. wlast=1 when count==cmd_len. After the last beat → W_RESP.
- W_RESP: bready=1. On bvalid, done_resp=bresp; if bid != cmd_id, force 10 → DONE.
- R_DATA: rd_valid=rvalid, rready=rd_ready, rd_data=rdata, rd_last=rlast.
  - Accumulate the worst rresp, using numeric max.
  - The burst terminates on rlast. If rlast arrives with count != cmd_len, or count reaches cmd_len without rlast, or any rid != cmd_id, done_resp is forced to 10.
  - Extra beats after the missing rlast are accepted until rlast arrives.
- DONE: done_valid=1 for one cycle → IDLE.
- Only one transaction is ever outstanding. Read and write never overlap.

## Timing
- Reset values:
  - awvalid, wvalid, bready, arvalid, rready, wr_ready, rd_valid, done_valid, busy: 0.
  - cmd_ready: 1.
  - done_resp: 00. Beat counter: 0. State: IDLE.
- Latency:
  - a*valid is asserted the cycle after the command is accepted.
  - done_valid is asserted the cycle after the bvalid/last-beat handshake.
  - Command-accept to next cmd_ready is at least cmd_len+4 cycles when the slave is zero-wait.
  - A rejected command gives done_valid 1 cycle after accept and cmd_ready 2 cycles after accept.
- Valid/ready handshakes: no valid is ever deasserted without a handshake. The command stays held with no ready dependency on valid.
- The counter is 8 bits and never wraps: the length check bounds it.
- Reset mid-burst aborts immediately to IDLE; all outputs return to reset values on the next edge.

## Structure
- Package axi_burst_pkg holds:
  - resp constants (OKAY/EXOKAY/SLVERR/DECERR)
  - burst type constants
  - state enum
  - function crosses_4k(addr, len, bytes_per_beat)
- No sub-module. Counter and checks stay inline.

## Test plan
- Write addr 0x100, len 3, data 0xA0..0xA3, zero-wait slave → awlen=3, awsize=2, four W beats with wlast on the 4th, done_resp=00, memory 0x100..0x10C holds the data.
- Read back the same burst with a random rvalid stall (rd_ready toggling) → rd_data 0xA0..0xA3 in order, rd_last on beat 4, done_resp=00, no lost or duplicated beats.
- Write addr 0xFF8, len 3 → no awvalid, done_valid 1 cycle after accept, done_resp=11.
- Read with cmd_len=16, MAX_BURST=16 → rejected with done_resp=11. Then cmd_len=15 is accepted with arlen=15.
- Read len 3 where the slave asserts rlast on beat 2, plus a bid-mismatched write → done_resp=10 for both, FSM returns to IDLE.
- Assert resetn=0 during beat 2 of a write → next cycle all valids are 0, cmd_ready=1, and a following single-beat write completes OKAY.
